// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state type and lane helpers for the load/store unit
//
// Purpose: funct3 encodings, FSM state enum, byte-enable generation and the
//          alignment/legality check used by lsu_dram.
// Ports:   none (package).
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Loads always fetch the whole word; the lane is picked after the ack.
  function automatic logic [3:0] be_gen(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (is_store) begin
      case (f3)
        F3_B:    be = 4'b0001 << off;
        F3_H:    be = 4'b0011 << {off[1], 1'b0};
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // True for a misaligned offset or an encoding the access type does not allow.
  function automatic logic bad_access(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    case (f3)
      F3_B:        bad = 1'b0;
      F3_H:        bad = off[0];
      F3_W:        bad = (off != 2'b00);
      F3_BU:       bad = is_store;
      F3_HU:       bad = is_store | off[0];
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extraction and sign/zero extension
//
// Purpose: pick the byte/half lane of a read word and extend it to 32 bits.
// Ports:   funct3 in 3  - load type (B/H/W/BU/HU)
//          off    in 2  - byte offset within the word
//          word   in 32 - raw bus read data
//          data   out 32 - extended load result
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);
  import lsu_pkg::*;

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_BU:   data = {24'h0, b};
      F3_HU:   data = {16'h0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu_dram.sv
// rtl/lsu_dram.sv - load/store unit: one req/ack bus transaction per access, with stall
//
// Purpose: launch a bus cycle for a load/store, stall the core until it completes,
//          return the extended load data, flag misaligned accesses and timeouts.
// Ports:   clk, rst_n (async active-low)
//          mem_rd, mem_wr, funct3, addr, wdata  - access request from the core
//          stall, rdata, misalign, err          - status/result to the core
//          bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_ack, bus_rdata - memory bus
module lsu_dram #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  import lsu_pkg::*;

  state_t      state;
  logic [7:0]  tcnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        bad;
  logic        access;
  logic [31:0] ext;
  logic [31:0] wrep;

  lsu_align u_align (
    .funct3 (f3_q),
    .off    (off_q),
    .word   (bus_rdata),
    .data   (ext)
  );

  always_comb begin
    // mem_wr wins when both strobes are set, so store rules apply.
    bad      = bad_access(mem_wr, funct3, addr[1:0]);
    misalign = (state == IDLE) & (mem_rd | mem_wr) & bad;
    access   = (state == IDLE) & (mem_rd | mem_wr) & ~bad;
    stall    = access | (state == REQ);
    case (funct3)
      F3_B:    wrep = {4{wdata[7:0]}};
      F3_H:    wrep = {2{wdata[15:0]}};
      default: wrep = wdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= 8'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      rdata     <= 32'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state     <= REQ;
            bus_req   <= 1'b1;
            bus_we    <= mem_wr;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_gen(mem_wr, funct3, addr[1:0]);
            bus_wdata <= wrep;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            tcnt      <= 8'd0;
          end
        end
        REQ: begin
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            rdata   <= bus_we ? 32'd0 : ext;
            err     <= 1'b0;
          end else if (tcnt == 8'(TIMEOUT - 1)) begin
            state   <= DONE;
            bus_req <= 1'b0;
            rdata   <= 32'd0;
            err     <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        DONE: begin
          // rdata/err are only meaningful in DONE; clear them on the way out.
          state <= IDLE;
          rdata <= 32'd0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
